// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: issues in-order ROM fetches under a credit limit and
// buffers returned words in a small FIFO presented to the core; redirects flush and drain.
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_gnt,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + MAX_OUT + 1) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic        gnt_fire_s;
  logic        rsp_drop_s;
  logic        rsp_push_s;
  logic        rsp_done_s;
  logic        pop_s;
  logic        push_en_s;
  logic [31:0] target_s;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];
  assign target_s         = {redirect_addr[31:2], 2'b00};

  // Gating on reset keeps both strobes low the instant reset rises.
  assign rom_req    = !reset && !redirect && (out_q < CW'(MAX_OUT)) &&
                      ((count_q + out_q - disc_q) < CW'(DEPTH));
  assign rom_addr   = fetch_pc_q;
  assign inst_valid = !reset && (count_q != {CW{1'b0}}) && !redirect;
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst       = inst_mem_q[rd_ptr_q];

  // Next-state computation for fetch/response pointers, FIFO and credit counters.
  always_comb begin
    gnt_fire_s = rom_req && rom_gnt;
    rsp_drop_s = rom_rvalid && (disc_q != {CW{1'b0}});
    rsp_push_s = rom_rvalid && (disc_q == {CW{1'b0}}) && (out_q != {CW{1'b0}});
    rsp_done_s = rsp_drop_s || rsp_push_s;
    pop_s      = inst_valid && !stall;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    disc_d     = disc_q;
    push_en_s  = 1'b0;

    if (redirect) begin
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      // Everything still in flight is stale; a response landing now retires one.
      if (rom_rvalid && (out_q != {CW{1'b0}})) begin
        out_d  = out_q - CW'(1);
        disc_d = out_q - CW'(1);
      end else begin
        out_d  = out_q;
        disc_d = out_q;
      end
    end else begin
      if (gnt_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (rsp_drop_s) begin
        disc_d = disc_q - CW'(1);
      end else begin
        disc_d = disc_q;
      end

      case ({gnt_fire_s, rsp_done_s})
        2'b10:   out_d = out_q + CW'(1);
        2'b01:   out_d = out_q - CW'(1);
        default: out_d = out_q;
      endcase

      if (rsp_push_s) begin
        push_en_s = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
        push_en_s = 1'b0;
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({rsp_push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      out_q      <= {CW{1'b0}};
      disc_q     <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  // FIFO storage; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= rom_rdata;
    end
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL take parameter DEPTH, default 4: instruction FIFO entries, power of two.
REQ-002 SHALL take parameter MAX_OUT, default 2: maximum ROM requests in flight.
REQ-003 SHALL take parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: the core cannot accept an instruction this cycle.
REQ-007 SHALL have port redirect, input, 1: branch/jump taken; restart fetch.
REQ-008 SHALL have port redirect_addr, input, 32: the restart target.
REQ-009 SHALL have port inst_valid, output, 1: the head entry is presented to the core.
REQ-010 SHALL have port inst_pc, output, 32: the PC of the head entry.
REQ-011 SHALL have port inst, output, 32: the instruction word of the head entry.
REQ-012 SHALL have port rom_req, output, 1: a fetch request.
REQ-013 SHALL have port rom_addr, output, 32: the fetch address, word aligned.
REQ-014 SHALL have port rom_gnt, input, 1: the ROM accepts the request this cycle.
REQ-015 SHALL have port rom_rvalid, input, 1: response data is valid; responses return in order, at least 1 cycle after grant.
REQ-016 SHALL have port rom_rdata, input, 32: the response instruction word.

Function
REQ-017 SHALL hold fetch_pc, resp_pc, a DEPTH-entry FIFO of {pc,inst}, count, outstanding and discard counters.
REQ-018 SHALL drive rom_req=1 only when: not in reset; redirect=0; outstanding<MAX_OUT; count+outstanding-discard<DEPTH.
REQ-019 SHALL drive rom_addr from fetch_pc.
REQ-020 SHALL, on a cycle with rom_req and rom_gnt both high, increment fetch_pc by 4 modulo 2^32 and increment outstanding.
REQ-021 SHALL, on rom_rvalid with discard>0, drop the data and decrement both discard and outstanding.
REQ-022 SHALL, on rom_rvalid with discard=0 and outstanding>0, push {resp_pc, rom_rdata}, increment resp_pc by 4 and decrement outstanding.
REQ-023 SHALL ignore rom_rvalid when outstanding=0 (protocol error): no push and no counter change.
REQ-024 SHALL compute inst_valid = (count>0) && !redirect, with inst_pc and inst taken from the head entry, combinationally.
REQ-025 SHALL pop the head when inst_valid && !stall.
REQ-026 SHALL allow push and pop in the same cycle with count unchanged; the credit rule in REQ-018 guarantees the FIFO never overflows.
REQ-027 SHALL, on redirect=1 in a cycle: empty the FIFO; load fetch_pc and resp_pc with {redirect_addr[31:2],2'b00}; set discard = outstanding minus any response arriving that cycle; ignore any pop or push that cycle.
REQ-028 SHALL accept back-to-back redirects, each restarting from its own target with discard recomputed.
REQ-029 SHALL wrap fetch_pc and resp_pc from 32'hFFFF_FFFC to 32'h0000_0000 silently.
REQ-030 SHALL be idle/running only; it SHALL NOT need a distinct FSM state, and discard>0 implicitly marks the draining phase.

Reset
REQ-031 SHALL, while reset=1: set fetch_pc=resp_pc=RESET_PC; count=outstanding=discard=0; inst_valid=0; rom_req=0.
REQ-032 SHALL, on reset asserted mid-operation, force inst_valid and rom_req low immediately, without waiting for a clock edge.
REQ-033 SHALL issue the first request, rom_addr=RESET_PC, in the first cycle after reset deasserts.

Verification
REQ-034 Reset release, gnt=1, 1-cycle response, stall=0 -> rom_addr 0,4,8,... on consecutive cycles; inst_valid first high 2 cycles after release with inst_pc=0; PCs consecutive thereafter.
REQ-035 stall held 1 -> FIFO fills to 4 entries; rom_req low once count+outstanding=4; release stall -> inst_pc 0,4,8,C in order with no gaps.
REQ-036 redirect to 32'h0000_0100 with 2 requests in flight -> next two rvalids dropped; first inst_valid shows inst_pc=0x100 with inst equal to the data returned for rom_addr 0x100.
REQ-037 redirect_addr=32'h0000_0103 -> rom_addr=0x100 and inst_pc=0x100.
REQ-038 fetch_pc reaches 32'hFFFF_FFFC -> next rom_addr=0, and inst_pc sequence is FFFF_FFFC then 0000_0000.
REQ-039 reset pulsed with 3 entries and 1 outstanding, mid-cycle -> inst_valid=0 and rom_req=0 asynchronously; after release, fetch restarts at RESET_PC and no stale entry appears.
